spi_bus_bridge: RTL

//  Turns framed SPI byte traffic from spi_target into native Xosera bus cycles
//  (cs_n, rd_nwr, reg_num, bytesel, data) that drive xosera_main when the board

---
 rtl/spi_bus_bridge_pkg.sv | 20 ++
 rtl/spi_bus_bridge_bus_cycle_gen.sv | 64 ++++++
 rtl/spi_bus_bridge.sv | 108 ++++++++++
 3 files changed

// File: rtl/spi_bus_bridge_pkg.sv
// Shared constants for the SPI-to-Xosera bus bridge: bus polarities, command
// bit positions and the bus timing counter width helper.
package spi_bus_bridge_pkg;
  localparam logic cs_ENABLED  = 1'b0;
  localparam logic cs_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;

  localparam int CMD_RD_BIT  = 7;
  localparam int CMD_INC_BIT = 6;

  // Counter only ever holds (phase length - 1), so clog2 of the longest phase suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/spi_bus_bridge_bus_cycle_gen.sv
// Xosera bus strobe timing: SETUP -> STROBE (cs_n low) -> GAP from a start pulse,
// sharing one down-counter across all three phases.
module spi_bus_bridge_bus_cycle_gen
  import spi_bus_bridge_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int CS_CYC    = 3,
  parameter int GAP_CYC   = 1
) (
  input  logic clk,
  input  logic reset_i,
  input  logic start_i,
  output logic cs_n_o,
  output logic busy_o,
  output logic sample_o,
  output logic done_o
);
  localparam int CW = cnt_width(SETUP_CYC, CS_CYC, GAP_CYC);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_GAP} phase_t;

  phase_t        phase;
  logic [CW-1:0] cnt;

  assign sample_o = (phase == PH_STROBE) && (cnt == '0);
  assign done_o   = (phase == PH_GAP) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      cs_n_o <= cs_DISABLED;
      busy_o <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE: if (start_i) begin
          phase  <= PH_SETUP;
          cnt    <= CW'(SETUP_CYC - 1);
          busy_o <= 1'b1;
        end
        PH_SETUP: if (cnt == '0) begin
          phase  <= PH_STROBE;
          cnt    <= CW'(CS_CYC - 1);
          cs_n_o <= cs_ENABLED;
        end else begin
          cnt <= cnt - 1'b1;
        end
        PH_STROBE: if (cnt == '0) begin
          phase  <= PH_GAP;
          cnt    <= CW'(GAP_CYC - 1);
          cs_n_o <= cs_DISABLED;
        end else begin
          cnt <= cnt - 1'b1;
        end
        PH_GAP: if (cnt == '0) begin
          phase  <= PH_IDLE;
          busy_o <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/spi_bus_bridge.sv
// Converts framed SPI bytes (command + data) into Xosera register bus cycles,
// with auto-increment bursts, read prefetch and sticky overrun status.
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int REG_BITS  = 4,
  parameter int SETUP_CYC = 1,
  parameter int CS_CYC    = 3,
  parameter int GAP_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                frame_active_i,
  input  logic                receive_strobe_i,
  input  logic [7:0]          receive_byte_i,
  input  logic                transmit_strobe_i,
  output logic [7:0]          transmit_byte_o,
  output logic                bus_cs_n_o,
  output logic                bus_rd_nwr_o,
  output logic [REG_BITS-1:0] bus_reg_num_o,
  output logic                bus_bytesel_o,
  output logic [7:0]          bus_data_o,
  input  logic [7:0]          bus_data_i,
  output logic                busy_o,
  output logic                overrun_o
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t state;
  logic   rd_mode, inc_mode;
  logic   cmd_rx, req, start, sample, done, ovr_nxt;

  assign cmd_rx = (state == CMD) && frame_active_i && receive_strobe_i;
  // The frame mode picks which strobe requests an access; the other is ignored.
  assign req    = (state == WAIT) && frame_active_i &&
                  (rd_mode ? transmit_strobe_i : receive_strobe_i);
  assign start  = (cmd_rx && receive_byte_i[CMD_RD_BIT]) || (req && !busy_o);

  always_comb begin
    ovr_nxt = overrun_o;
    if (cmd_rx)            ovr_nxt = 1'b0;
    else if (req && busy_o) ovr_nxt = 1'b1;
  end

  spi_bus_bridge_bus_cycle_gen #(
    .SETUP_CYC(SETUP_CYC),
    .CS_CYC   (CS_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_cycle (
    .clk     (clk),
    .reset_i (reset_i),
    .start_i (start),
    .cs_n_o  (bus_cs_n_o),
    .busy_o  (busy_o),
    .sample_o(sample),
    .done_o  (done)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state           <= IDLE;
      rd_mode         <= 1'b0;
      inc_mode        <= 1'b0;
      bus_rd_nwr_o    <= RnW_READ;
      bus_reg_num_o   <= '0;
      bus_bytesel_o   <= 1'b0;
      bus_data_o      <= 8'h00;
      transmit_byte_o <= 8'h00;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= ovr_nxt;

      case (state)
        IDLE: if (frame_active_i) state <= CMD;
        CMD: if (!frame_active_i) begin
          state <= IDLE;
        end else if (receive_strobe_i) begin
          state         <= WAIT;
          rd_mode       <= receive_byte_i[CMD_RD_BIT];
          inc_mode      <= receive_byte_i[CMD_INC_BIT];
          bus_reg_num_o <= receive_byte_i[REG_BITS-1:0];
          bus_bytesel_o <= 1'b0;
          if (receive_byte_i[CMD_RD_BIT]) bus_rd_nwr_o <= RnW_READ;
        end
        // An access in flight always finishes before the frame is abandoned.
        WAIT: if (!frame_active_i && !busy_o) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (req && !busy_o && !rd_mode) begin
        bus_data_o   <= receive_byte_i;
        bus_rd_nwr_o <= RnW_WRITE;
      end

      if (done) begin
        bus_bytesel_o <= ~bus_bytesel_o;
        if (bus_bytesel_o && inc_mode) bus_reg_num_o <= bus_reg_num_o + 1'b1;
      end

      if (cmd_rx && !receive_byte_i[CMD_RD_BIT])
        transmit_byte_o <= 8'h00;
      else if (sample && (bus_rd_nwr_o == RnW_READ))
        transmit_byte_o <= bus_data_i;
      else if ((state == WAIT) && !rd_mode)
        transmit_byte_o <= {ovr_nxt, 7'b0};
    end
  end
endmodule
